register_file: RTL

- Architectural register file with rename tags. Sits directly downstream of the reorder buffer's commit port and beside the decoder.
- Holds 32 committed register values plus a per-register busy bit and the ROB tag of the latest in-flight producer.
- Serves combinational operand lookups to the decoder, records renames at issue, retires values on ROB commit, and clears all renames on a misprediction flush.

---
 rtl/register_file_if.sv | 46 ++++
 rtl/register_file.sv | 105 ++++++++++
 2 files changed

// File: rtl/register_file_if.sv
// Bundles the decoder lookup, issue-rename and ROB-commit signals around the
// architectural register file; slave is the register file side.
interface register_file_if #(
    parameter int REG_INDEX_WIDTH = 5,
    parameter int ROB_INDEX_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
);
    logic                       rdy_in;
    logic                       clr_in;

    logic [REG_INDEX_WIDTH-1:0] dc_rs1_index;
    logic [REG_INDEX_WIDTH-1:0] dc_rs2_index;
    logic [DATA_WIDTH-1:0]      reg_to_dc_rs1_val;
    logic                       reg_to_dc_rs1_busy;
    logic [ROB_INDEX_WIDTH-1:0] reg_to_dc_rs1_tag;
    logic [DATA_WIDTH-1:0]      reg_to_dc_rs2_val;
    logic                       reg_to_dc_rs2_busy;
    logic [ROB_INDEX_WIDTH-1:0] reg_to_dc_rs2_tag;

    logic                       issue_ready;
    logic [REG_INDEX_WIDTH-1:0] issue_rd;
    logic [ROB_INDEX_WIDTH-1:0] issue_rob_index;

    logic                       rob_to_reg_commit;
    logic [REG_INDEX_WIDTH-1:0] rob_to_reg_index;
    logic [ROB_INDEX_WIDTH-1:0] rob_to_reg_rob_index;
    logic [DATA_WIDTH-1:0]      rob_to_reg_val;

    modport slave (
        input  rdy_in, clr_in,
        input  dc_rs1_index, dc_rs2_index,
        output reg_to_dc_rs1_val, reg_to_dc_rs1_busy, reg_to_dc_rs1_tag,
        output reg_to_dc_rs2_val, reg_to_dc_rs2_busy, reg_to_dc_rs2_tag,
        input  issue_ready, issue_rd, issue_rob_index,
        input  rob_to_reg_commit, rob_to_reg_index, rob_to_reg_rob_index, rob_to_reg_val
    );

    modport master (
        output rdy_in, clr_in,
        output dc_rs1_index, dc_rs2_index,
        input  reg_to_dc_rs1_val, reg_to_dc_rs1_busy, reg_to_dc_rs1_tag,
        input  reg_to_dc_rs2_val, reg_to_dc_rs2_busy, reg_to_dc_rs2_tag,
        output issue_ready, issue_rd, issue_rob_index,
        output rob_to_reg_commit, rob_to_reg_index, rob_to_reg_rob_index, rob_to_reg_val
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and producer ROB tag;
// zero-latency operand lookup with commit bypass, rename at issue, flush on clr_in.
module register_file #(
    parameter int REG_NUM         = 32,
    parameter int REG_INDEX_WIDTH = 5,
    parameter int ROB_INDEX_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    register_file_if.slave   rf
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      val;
        logic                       busy;
        logic [ROB_INDEX_WIDTH-1:0] tag;
    } lookup_t;

    logic [DATA_WIDTH-1:0]      val_q  [REG_NUM];
    logic [DATA_WIDTH-1:0]      val_d  [REG_NUM];
    logic [REG_NUM-1:0]         busy_q;
    logic [REG_NUM-1:0]         busy_d;
    logic [ROB_INDEX_WIDTH-1:0] tag_q  [REG_NUM];
    logic [ROB_INDEX_WIDTH-1:0] tag_d  [REG_NUM];

    lookup_t lk1;
    lookup_t lk2;

    // Bypass only when the committing entry is the register's current producer,
    // so a stale commit never hides a younger outstanding rename.
    function automatic lookup_t lookup(
        input logic [REG_INDEX_WIDTH-1:0] rs,
        input logic                       commit,
        input logic [REG_INDEX_WIDTH-1:0] commit_rd,
        input logic [ROB_INDEX_WIDTH-1:0] commit_tag,
        input logic [DATA_WIDTH-1:0]      commit_val
    );
        lookup_t r;
        r.val  = '0;
        r.busy = 1'b0;
        r.tag  = '0;
        if (rs != '0) begin
            if (commit && commit_rd == rs && busy_q[rs] && tag_q[rs] == commit_tag) begin
                r.val  = commit_val;
                r.busy = 1'b0;
                r.tag  = tag_q[rs];
            end else begin
                r.val  = val_q[rs];
                r.busy = busy_q[rs];
                r.tag  = tag_q[rs];
            end
        end
        return r;
    endfunction

    always_comb begin
        lk1 = lookup(rf.dc_rs1_index, rf.rob_to_reg_commit, rf.rob_to_reg_index,
                     rf.rob_to_reg_rob_index, rf.rob_to_reg_val);
        lk2 = lookup(rf.dc_rs2_index, rf.rob_to_reg_commit, rf.rob_to_reg_index,
                     rf.rob_to_reg_rob_index, rf.rob_to_reg_val);
    end

    assign rf.reg_to_dc_rs1_val  = lk1.val;
    assign rf.reg_to_dc_rs1_busy = lk1.busy;
    assign rf.reg_to_dc_rs1_tag  = lk1.tag;
    assign rf.reg_to_dc_rs2_val  = lk2.val;
    assign rf.reg_to_dc_rs2_busy = lk2.busy;
    assign rf.reg_to_dc_rs2_tag  = lk2.tag;

    // Commit first, then flush or rename, so a same-register rename wins busy/tag.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rf.rdy_in) begin
            if (rf.rob_to_reg_commit && rf.rob_to_reg_index != '0) begin
                val_d[rf.rob_to_reg_index] = rf.rob_to_reg_val;
                if (tag_q[rf.rob_to_reg_index] == rf.rob_to_reg_rob_index)
                    busy_d[rf.rob_to_reg_index] = 1'b0;
            end
            if (rf.clr_in) begin
                busy_d = '0;
            end else if (rf.issue_ready && rf.issue_rd != '0) begin
                busy_d[rf.issue_rd] = 1'b1;
                tag_d[rf.issue_rd]  = rf.issue_rob_index;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule
